serial_add_ctrl: RTL

//  Bit-serial adder controller: sequences one shared full-adder cell (two half_adder

---
 rtl/serial_add_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one shared full-adder cell stepped LSB first over WIDTH cycles
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d;
  logic s0, c0, s1, c1;
  half_adder ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(s0), .c_o(c0));
  half_adder ha1 (.a_i(s0), .b_i(carry_q), .s_o(s1), .c_o(c1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && in_valid) state_d = RUN;
    if (state_q == RUN && cnt_q == LAST) state_d = DONE;
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  // Datapath: load on acceptance, shift one bit per RUN cycle, hold otherwise
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (state_q == IDLE && in_valid) begin
      cnt_d   = '0;
      carry_d = cin;
      a_d     = a;
      b_d     = b;
    end else if (state_q == RUN) begin
      cnt_d   = cnt_q + CW'(1);
      carry_d = c0 | c1;
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = {s1, sum_q[WIDTH-1:1]};
    end
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    sum       = (state_q == DONE) ? sum_q : '0;
    cout      = (state_q == DONE) ? carry_q : 1'b0;
  end
endmodule
